// File: rtl/tq_pkg.sv
// Shared definitions for the tq transform path: odd-part widths, the
// scheduler FSM states, and the coefficient/sign tables of the 8-point DCT
// odd butterfly.
package tq_pkg;

  localparam int unsigned IN_W   = 19;
  localparam int unsigned ACC_W  = 27;
  localparam int unsigned PROD_W = 26;  // |89 * -2^18| fits in 26 bits signed

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Multiplier output select: 0 = x18, 1 = x50, 2 = x75, 3 = x89
  typedef enum logic [1:0] {
    C18 = 2'd0,
    C50 = 2'd1,
    C75 = 2'd2,
    C89 = 2'd3
  } coef_e;

  // Bit {cnt, k} set means output Ok subtracts its product on step cnt
  localparam logic [15:0] SIGN_TBL = 16'b1010_0010_1110_0000;

  // Which constant output Ok uses on step cnt
  function automatic coef_e coef_sel(input logic [1:0] cnt, input logic [1:0] k);
    coef_e c;
    case ({cnt, k})
      4'h0: c = C89;  4'h1: c = C75;  4'h2: c = C50;  4'h3: c = C18;
      4'h4: c = C75;  4'h5: c = C18;  4'h6: c = C89;  4'h7: c = C50;
      4'h8: c = C50;  4'h9: c = C89;  4'hA: c = C18;  4'hB: c = C75;
      default: begin
        case (k)
          2'd0:    c = C18;
          2'd1:    c = C50;
          2'd2:    c = C75;
          default: c = C89;
        endcase
      end
    endcase
    return c;
  endfunction

  function automatic logic is_neg(input logic [1:0] cnt, input logic [1:0] k);
    return SIGN_TBL[{cnt, k}];
  endfunction

endpackage

// File: rtl/spiral_4.sv
// spiral_4: shift-add four-constant multiplier producing x*18, x*50, x*75,
// x*89 from one 19-bit signed operand. Purely combinational.
//   x                 : signed multiplicand
//   p18, p50, p75, p89: signed products
module spiral_4
  import tq_pkg::*;
(
  input  logic signed [IN_W-1:0]   x,
  output logic signed [PROD_W-1:0] p18,
  output logic signed [PROD_W-1:0] p50,
  output logic signed [PROD_W-1:0] p75,
  output logic signed [PROD_W-1:0] p89
);

  logic signed [PROD_W-1:0] xe;
  logic signed [PROD_W-1:0] x9;
  logic signed [PROD_W-1:0] x25;

  assign xe  = PROD_W'(x);
  assign x9  = xe + (xe <<< 3);
  assign x25 = x9 + (xe <<< 4);

  assign p18 = x9 <<< 1;
  assign p50 = x25 <<< 1;
  assign p75 = x25 + (x25 <<< 1);
  assign p89 = x25 + (xe <<< 6);

endmodule

// File: rtl/dct8_odd_sched.sv
// dct8_odd_sched: odd half of the 8-point forward DCT partial butterfly,
// time-multiplexed over one shared four-constant multiplier. A row a0..a3 is
// latched, then a[cnt] is multiplied on four MAC cycles and the signed
// products are accumulated into O0..O3.
//   clk, rst          : clock, asynchronous active-high reset
//   i_valid, i_ready  : input row handshake (ready only in IDLE)
//   i_data_0..3       : signed odd inputs a0..a3
//   o_valid, o_ready  : output handshake (valid only in OUT)
//   o_data_0..3       : signed odd outputs O0..O3
// Optional feature: define DCT8_ODD_SCHED_ROUND_EN to round the outputs by
// (acc + 2^(SHIFT-1)) >>> SHIFT; otherwise the accumulators drive o_data.
module dct8_odd_sched
  import tq_pkg::*;
#(
  parameter int unsigned SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic signed [IN_W-1:0]  i_data_0,
  input  logic signed [IN_W-1:0]  i_data_1,
  input  logic signed [IN_W-1:0]  i_data_2,
  input  logic signed [IN_W-1:0]  i_data_3,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [ACC_W-1:0] o_data_0,
  output logic signed [ACC_W-1:0] o_data_1,
  output logic signed [ACC_W-1:0] o_data_2,
  output logic signed [ACC_W-1:0] o_data_3
);

  state_e                   state;
  logic [1:0]               cnt;
  logic signed [IN_W-1:0]   a       [4];
  logic signed [ACC_W-1:0]  acc     [4];
  logic signed [PROD_W-1:0] prod    [4];
  logic signed [ACC_W-1:0]  contrib [4];
  logic signed [ACC_W-1:0]  dout    [4];

  // Legal SHIFT range is 1..8
  if (SHIFT < 1 || SHIFT > 8) begin : g_shift_out_of_range
  end

  spiral_4 u_spiral (
    .x   (a[cnt]),
    .p18 (prod[0]),
    .p50 (prod[1]),
    .p75 (prod[2]),
    .p89 (prod[3])
  );

  // Signed contribution of the current product to each output
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      contrib[k] = ACC_W'(prod[coef_sel(cnt, 2'(k))]);
      if (is_neg(cnt, 2'(k))) begin
        contrib[k] = -contrib[k];
      end
    end
  end

  // Decoded from state so that it reads 0 while reset is held
  assign i_ready = (state == IDLE) && !rst;

  // FSM, input latch, counter and accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      o_valid <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        a[k]   <= '0;
        acc[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a[0]  <= i_data_0;
            a[1]  <= i_data_1;
            a[2]  <= i_data_2;
            a[3]  <= i_data_3;
            cnt   <= 2'd0;
            state <= MAC;
          end
        end
        MAC: begin
          // Step 0 loads the accumulators, so no clear cycle is needed
          for (int k = 0; k < 4; k++) begin
            acc[k] <= (cnt == 2'd0) ? contrib[k] : acc[k] + contrib[k];
          end
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state   <= OUT;
            o_valid <= 1'b1;
          end
        end
        OUT: begin
          if (o_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCT8_ODD_SCHED_ROUND_EN
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(2 ** (SHIFT - 1));

  logic signed [ACC_W:0] rsum [4];

  // Round-half-up then arithmetic shift; widened by one bit for the add
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rsum[k] = (ACC_W+1)'(acc[k]) + RND;
      dout[k] = ACC_W'(rsum[k] >>> SHIFT);
    end
  end
`else
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dout[k] = acc[k];
    end
  end
`endif

  assign o_data_0 = dout[0];
  assign o_data_1 = dout[1];
  assign o_data_2 = dout[2];
  assign o_data_3 = dout[3];

endmodule
